wb_forward_unit: RTL

//  Producer end of the operand-forwarding path in the 3-stage RV32I pipeline. Tracks the stage-3

---
 rtl/wb_forward_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/wb_forward_unit.sv
// Writeback/forwarding producer for the 3-stage RV32I pipeline: commits stage-3 results,
// keeps a short write history and feeds stage-2 operand muxes. FWD_RS2_EN builds rs2 forwarding.
module wb_forward_unit #(
    parameter int XLEN       = 32,
    parameter int HIST_DEPTH = 2,
    parameter int LOAD_TO    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s3_valid,
    input  logic [31:0]     s3_inst,
    input  logic [XLEN-1:0] s3_result,
    input  logic [XLEN-1:0] ld_data,
    input  logic            ld_valid,
    input  logic [31:0]     s2_inst,
    output logic [1:0]      fwd1_sel,
    output logic [XLEN-1:0] fwd1_data,
    output logic [1:0]      fwd2_sel,
    output logic [XLEN-1:0] fwd2_data,
    output logic            stall,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            err_timeout
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam int CNT_W = $clog2(LOAD_TO + 1);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [4:0]       ld_rd;

    logic [HIST_DEPTH-1:0] hist_valid;
    logic [4:0]            hist_rd   [HIST_DEPTH];
    logic [XLEN-1:0]       hist_data [HIST_DEPTH];

    logic [6:0] s3_op, s2_op;
    logic [4:0] s3_rd, s2_rs1, s2_rs2;
    logic       s3_has_rd, s3_is_load;
    logic       s2_has_rs1, s2_has_rs2;
    logic       unused_inst_bits;

    assign s3_op      = s3_inst[6:0];
    assign s3_rd      = s3_inst[11:7];
    assign s3_has_rd  = (s3_op != OPC_BRANCH) && (s3_op != OPC_STORE) && (s3_rd != 5'd0);
    assign s3_is_load = (s3_op == OPC_LOAD);

    assign s2_op      = s2_inst[6:0];
    assign s2_rs1     = s2_inst[19:15];
    assign s2_rs2     = s2_inst[24:20];
    assign s2_has_rs1 = (s2_op != OPC_LUI) && (s2_op != OPC_AUIPC) && (s2_op != OPC_JAL);
    assign s2_has_rs2 = (s2_op == OPC_OP) || (s2_op == OPC_STORE) || (s2_op == OPC_BRANCH);

    assign unused_inst_bits = ^{s3_inst[31:12], s2_inst[31:25], s2_inst[14:7]};

    logic            commit;
    logic [4:0]      commit_rd;
    logic [XLEN-1:0] commit_data;
    logic            go_wait;

    always_comb begin
        commit      = 1'b0;
        commit_rd   = s3_rd;
        commit_data = s3_result;
        go_wait     = 1'b0;
        if (state == IDLE) begin
            if (s3_valid && s3_has_rd) begin
                if (!s3_is_load) begin
                    commit = 1'b1;
                end else if (ld_valid) begin
                    commit      = 1'b1;
                    commit_data = ld_data;
                end else begin
                    go_wait = 1'b1;
                end
            end
        end else if (ld_valid) begin
            commit      = 1'b1;
            commit_rd   = ld_rd;
            commit_data = ld_data;
        end
    end

    // The in-flight forwarding case is exactly the write about to commit this edge,
    // so it reuses the commit decode instead of re-deriving it per state.
    function automatic logic [XLEN+1:0] fwd_lookup(input logic [4:0] r, input logic used);
        logic [1:0]      sel;
        logic [XLEN-1:0] data;
        int unsigned     j;
        sel  = 2'b00;
        data = '0;
        for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
            j = HIST_DEPTH - 1 - i;
            if (hist_valid[j] && (hist_rd[j] == r)) begin
                sel  = 2'b10;
                data = hist_data[j];
            end
        end
        if (commit && (commit_rd == r)) begin
            sel  = 2'b01;
            data = commit_data;
        end
        if (!used || (r == 5'd0)) begin
            sel  = 2'b00;
            data = '0;
        end
        return {sel, data};
    endfunction

    always_comb begin
        {fwd1_sel, fwd1_data} = fwd_lookup(s2_rs1, s2_has_rs1);
`ifdef FWD_RS2_EN
        {fwd2_sel, fwd2_data} = fwd_lookup(s2_rs2, s2_has_rs2);
`else
        fwd2_sel  = 2'b00;
        fwd2_data = '0;
`endif
    end

    logic load_use_idle;
    assign load_use_idle = (state == IDLE) && s3_valid && s3_has_rd && s3_is_load && !ld_valid &&
                           ((s2_has_rs1 && (s2_rs1 == s3_rd)) || (s2_has_rs2 && (s2_rs2 == s3_rd)));

    assign stall = (state == LOAD_WAIT) ? !ld_valid : load_use_idle;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            ld_rd       <= '0;
            hist_valid  <= '0;
            wb_we       <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            err_timeout <= 1'b0;
        end else begin
            wb_we <= commit;
            if (commit) begin
                wb_rd   <= commit_rd;
                wb_data <= commit_data;
                for (int unsigned i = HIST_DEPTH - 1; i > 0; i--) begin
                    hist_valid[i] <= hist_valid[i-1];
                    hist_rd[i]    <= hist_rd[i-1];
                    hist_data[i]  <= hist_data[i-1];
                end
                hist_valid[0] <= 1'b1;
                hist_rd[0]    <= commit_rd;
                hist_data[0]  <= commit_data;
            end
            case (state)
                IDLE: begin
                    if (go_wait) begin
                        state    <= LOAD_WAIT;
                        wait_cnt <= '0;
                        ld_rd    <= s3_rd;
                    end
                end
                LOAD_WAIT: begin
                    if (ld_valid) begin
                        state <= IDLE;
                    end else if (wait_cnt < CNT_W'(LOAD_TO)) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (wait_cnt == CNT_W'(LOAD_TO - 1)) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
